// File: rtl/cd_tx_frame_if.sv
// cd_tx_frame_if: bundle of every non-clock/reset signal of cd_tx_frame.
//   master : the frame feeder (cd_tx_frame) side
//   slave  : the environment side (buffer logic, frame RAM, serializer)
// Signal groups:
//   frame_valid/frame_done/frame_err/frame_cd  buffer status and completion pulses
//   ram_rd_en/ram_rd_addr/ram_rd_data           frame RAM read port (1-cycle latency)
//   data/has_data/ack_data/is_crc_byte/
//   is_last_byte/crc_data                       serializer byte handshake
//   break_req/has_break/ack_break               break request handshake
//   cd/err/abort                                serializer event pulses
interface cd_tx_frame_if;
    logic        frame_valid;
    logic        frame_done;
    logic        frame_err;
    logic        frame_cd;
    logic        ram_rd_en;
    logic [7:0]  ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  data;
    logic        has_data;
    logic        ack_data;
    logic        is_crc_byte;
    logic        is_last_byte;
    logic [15:0] crc_data;
    logic        break_req;
    logic        has_break;
    logic        ack_break;
    logic        cd;
    logic        err;
    logic        abort;

    modport master (
        input  frame_valid, ram_rd_data, ack_data, crc_data, break_req, ack_break, cd, err,
               abort,
        output frame_done, frame_err, frame_cd, ram_rd_en, ram_rd_addr, data, has_data,
               is_crc_byte, is_last_byte, has_break
    );

    modport slave (
        output frame_valid, ram_rd_data, ack_data, crc_data, break_req, ack_break, cd, err,
               abort,
        input  frame_done, frame_err, frame_cd, ram_rd_en, ram_rd_addr, data, has_data,
               is_crc_byte, is_last_byte, has_break
    );
endinterface

// File: rtl/cd_tx_frame.sv
// cd_tx_frame: feeds one frame (src, dst, len, data...) from the TX frame buffer RAM to the
// byte serializer, then appends the two live CRC bytes and flags the final byte. Handles
// collision retry, error drop, abort and break requests.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    cd_tx_frame_if.master (buffer status, RAM read port, serializer handshake,
//          break handshake, cd/err/abort event pulses)
module cd_tx_frame #(
    parameter int unsigned MAX_DATA  = 253, // larger len bytes are clamped to this
    parameter int unsigned MAX_RETRY = 0    // collisions before drop; 0 retries forever
) (
    input logic           clk,
    input logic           reset,
    cd_tx_frame_if.master bus
);

    localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [7:0] MAX_DATA8 = 8'(MAX_DATA);

    typedef enum logic [2:0] {StIdle, StRd, StSend, StCrcL, StCrcH} state_e;

    state_e        state;
    logic [8:0]    idx;
    logic [8:0]    last_idx;
    logic [RW-1:0] retry_cnt;
    logic          hold;
    logic [7:0]    data_q;
    logic          has_data_q;
    logic          is_crc_q;
    logic          is_last_q;
    logic          has_break_q;
    logic          done_q;
    logic          err_q;
    logic          cd_q;

    logic          active;
    logic          launch;
    logic          advance;
    logic [7:0]    len_clamped;
    logic [RW-1:0] retry_inc;
    logic          retry_limit;

    assign active = (state != StIdle);

    // The RAM needs its strobe one cycle before RD samples ram_rd_data, so the read request
    // is decoded combinationally in the cycle that leaves IDLE or accepts an ack in SEND.
    assign launch  = !reset && (state == StIdle) && bus.frame_valid && !hold && !bus.abort;
    assign advance = (state == StSend) && bus.ack_data && (idx != last_idx) &&
                     !bus.abort && !bus.err && !bus.cd;

    assign bus.ram_rd_en   = launch || advance;
    assign bus.ram_rd_addr = advance ? (idx[7:0] + 8'd1) : idx[7:0];

    assign len_clamped = (bus.ram_rd_data > MAX_DATA8) ? MAX_DATA8 : bus.ram_rd_data;

    assign retry_inc   = (retry_cnt == '1) ? retry_cnt : (retry_cnt + RW'(1));
    assign retry_limit = (MAX_RETRY != 0) && (retry_inc == RETRY_MAX);

    // CRC bytes come straight from the serializer's running CRC, not from a register.
    assign bus.data = is_crc_q ? (is_last_q ? bus.crc_data[15:8] : bus.crc_data[7:0]) : data_q;

    assign bus.has_data     = has_data_q;
    assign bus.is_crc_byte  = is_crc_q;
    assign bus.is_last_byte = is_last_q;
    assign bus.has_break    = has_break_q;
    assign bus.frame_done   = done_q;
    assign bus.frame_err    = err_q;
    assign bus.frame_cd     = cd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            idx         <= '0;
            last_idx    <= 9'd2;
            retry_cnt   <= '0;
            hold        <= 1'b0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            is_crc_q    <= 1'b0;
            is_last_q   <= 1'b0;
            has_break_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cd_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cd_q   <= 1'b0;

            // Done/drop below overrides this clear; hold then falls once frame_valid is low.
            if (!bus.frame_valid) begin
                hold <= 1'b0;
            end

            // Break path is independent of the frame FSM; clear wins over a new request.
            if (bus.ack_break || bus.abort) begin
                has_break_q <= 1'b0;
            end else if (bus.break_req) begin
                has_break_q <= 1'b1;
            end

            if (bus.abort) begin
                state      <= StIdle;
                has_data_q <= 1'b0;
                is_crc_q   <= 1'b0;
                is_last_q  <= 1'b0;
                idx        <= '0;
                retry_cnt  <= '0;
            end else if (active && bus.err) begin
                state      <= StIdle;
                err_q      <= 1'b1;
                has_data_q <= 1'b0;
                is_crc_q   <= 1'b0;
                is_last_q  <= 1'b0;
                hold       <= 1'b1;
                idx        <= '0;
                retry_cnt  <= '0;
            end else if (active && bus.cd) begin
                state      <= StIdle;
                has_data_q <= 1'b0;
                is_crc_q   <= 1'b0;
                is_last_q  <= 1'b0;
                idx        <= '0;
                if (retry_limit) begin
                    err_q     <= 1'b1;
                    hold      <= 1'b1;
                    retry_cnt <= '0;
                end else begin
                    cd_q      <= 1'b1;
                    retry_cnt <= retry_inc;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        if (launch) begin
                            last_idx <= 9'd2;
                            state    <= StRd;
                        end
                    end
                    StRd: begin
                        data_q <= bus.ram_rd_data;
                        if (idx == 9'd2) begin
                            last_idx <= 9'd2 + {1'b0, len_clamped};
                        end
                        has_data_q <= 1'b1;
                        state      <= StSend;
                    end
                    StSend: begin
                        if (bus.ack_data) begin
                            if (idx == last_idx) begin
                                is_crc_q <= 1'b1;
                                state    <= StCrcL;
                            end else begin
                                // has_data stays high across the RAM read gap
                                idx   <= idx + 9'd1;
                                state <= StRd;
                            end
                        end
                    end
                    StCrcL: begin
                        if (bus.ack_data) begin
                            is_last_q <= 1'b1;
                            state     <= StCrcH;
                        end
                    end
                    StCrcH: begin
                        if (bus.ack_data) begin
                            has_data_q <= 1'b0;
                            is_crc_q   <= 1'b0;
                            is_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            hold       <= 1'b1;
                            idx        <= '0;
                            retry_cnt  <= '0;
                            state      <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cd_tx_frame.sv
// tb_cd_tx_frame: directed self-checking bench for cd_tx_frame (MAX_DATA=253, MAX_RETRY=2).
// Models the frame RAM (1-cycle read latency) and a serializer that acks bytes after a gap.
module tb_cd_tx_frame;

    logic clk;
    logic reset;

    cd_tx_frame_if bus ();

    cd_tx_frame #(
        .MAX_DATA  (253),
        .MAX_RETRY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] ram_q = 8'h00;
    logic [7:0] rd_log [$];

    assign bus.ram_rd_data = ram_q;

    always @(posedge clk) begin
        if (!reset && bus.ram_rd_en) begin
            ram_q <= mem[bus.ram_rd_addr];
            rd_log.push_back(bus.ram_rd_addr);
        end
    end

    int n_done = 0;
    int n_err  = 0;
    int n_cd   = 0;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) n_done++;
        if (bus.frame_err === 1'b1)  n_err++;
        if (bus.frame_cd === 1'b1)   n_cd++;
    end

    logic [7:0] cap_data [0:259];
    logic       cap_crc  [0:259];
    logic       cap_last [0:259];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    function automatic logic [31:0] first_addr();
        if (rd_log.size() == 0) return 32'hFFFF;
        return 32'(rd_log[0]);
    endfunction

    // Serializer model: waits gap cycles, then a bounded wait for has_data, captures, acks.
    task automatic serve(input int n, input int gap, output int drops, output int timeouts);
        int w;
        drops    = 0;
        timeouts = 0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (k > 0 && bus.has_data !== 1'b1) drops++;
            end
            w = 0;
            while (bus.has_data !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (bus.has_data !== 1'b1) timeouts++;
            cap_data[k]  = bus.data;
            cap_crc[k]   = bus.is_crc_byte;
            cap_last[k]  = bus.is_last_byte;
            bus.ack_data = 1'b1;
            @(negedge clk);
            bus.ack_data = 1'b0;
        end
    endtask

    task automatic revalid();
        bus.frame_valid = 1'b0;
        cycles(2);
        rd_log.delete();
        bus.frame_valid = 1'b1;
    endtask

    initial begin
        logic [7:0] e1 [0:7];
        logic [7:0] e2 [0:4];
        int drops, tmo, mism, nlast, d0, e0, c0;

        reset           = 1'b0;
        bus.frame_valid = 1'b0;
        bus.ack_data    = 1'b0;
        bus.crc_data    = 16'h1234;
        bus.break_req   = 1'b0;
        bus.ack_break   = 1'b0;
        bus.cd          = 1'b0;
        bus.err         = 1'b0;
        bus.abort       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #2 reset = 1'b1;
        cycles(2);

        // Reset values
        chk("rst_has_data", 32'(bus.has_data), 32'd0);
        chk("rst_flags", 32'({bus.has_break, bus.is_crc_byte, bus.is_last_byte, bus.ram_rd_en}),
            32'd0);
        chk("rst_pulses", 32'({bus.frame_done, bus.frame_err, bus.frame_cd}), 32'd0);
        chk("rst_data_addr", 32'({bus.data, bus.ram_rd_addr}), 32'd0);
        reset = 1'b0;
        cycles(1);

        // Frame 1: 01 02 03 AA BB CC, crc 0x1234, ack every 40 cycles
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
        e1 = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h34, 8'h12};
        d0 = n_done;
        rd_log.delete();
        bus.frame_valid = 1'b1;
        serve(8, 40, drops, tmo);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_byte%0d", k), 32'({cap_last[k], cap_crc[k], cap_data[k]}),
                32'({(k == 7), (k >= 6), e1[k]}));
        end
        chk("t1_gaps", 32'(drops + tmo), 32'd0);
        cycles(3);
        chk("t1_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t1_has_data_off", 32'(bus.has_data), 32'd0);
        cycles(10);
        // hold keeps a still-valid buffer from relaunching
        chk("t1_rd_cnt", 32'(rd_log.size()), 32'd6);
        chk("t1_last_addr", 32'(rd_log[rd_log.size() - 1]), 32'd5);

        // Frame 2: len = 0
        mem[0] = 8'h05; mem[1] = 8'h06; mem[2] = 8'h00;
        bus.crc_data = 16'hBEEF;
        e2 = '{8'h05, 8'h06, 8'h00, 8'hEF, 8'hBE};
        d0 = n_done;
        revalid();
        serve(5, 3, drops, tmo);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_byte%0d", k), 32'({cap_last[k], cap_crc[k], cap_data[k]}),
                32'({(k == 4), (k >= 3), e2[k]}));
        end
        cycles(3);
        chk("t2_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t2_no_extra", 32'({bus.has_data, 8'(rd_log.size())}), 32'({1'b0, 8'd3}));

        // Frame 3: len 0xFF clamped to 253 -> 256 RAM bytes
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFF;
        for (int i = 3; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        bus.crc_data = 16'hC3A5;
        d0 = n_done;
        revalid();
        serve(258, 2, drops, tmo);
        mism  = 0;
        nlast = 0;
        for (int k = 0; k < 256; k++) begin
            if (cap_data[k] !== mem[k] || cap_crc[k] !== 1'b0) mism++;
        end
        for (int k = 0; k < 258; k++) if (cap_last[k] === 1'b1) nlast++;
        chk("t3_data", 32'(mism + tmo + drops), 32'd0);
        chk("t3_crc", 32'({cap_crc[256], cap_data[256], cap_crc[257], cap_data[257]}),
            32'({1'b1, 8'hA5, 1'b1, 8'hC3}));
        chk("t3_last", 32'({8'(nlast), cap_last[257]}), 32'({8'd1, 1'b1}));
        cycles(3);
        chk("t3_rd_cnt", 32'(rd_log.size()), 32'd256);
        chk("t3_last_addr", 32'(rd_log[rd_log.size() - 1]), 32'd255);
        chk("t3_done_cnt", 32'(n_done - d0), 32'd1);

        // Collision retry: cd on byte 3, then again -> drop at MAX_RETRY = 2
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
        bus.crc_data = 16'h1234;
        revalid();
        serve(3, 3, drops, tmo);
        cycles(3);
        chk("t4_on_byte3", 32'({bus.has_data, bus.data}), 32'({1'b1, 8'hAA}));
        rd_log.delete();
        bus.cd = 1'b1;
        @(negedge clk);
        bus.cd = 1'b0;
        chk("t4_cd_pulse", 32'({bus.frame_cd, bus.frame_err, bus.has_data}), 32'b100);
        cycles(3);
        chk("t4_restart_addr", first_addr(), 32'd0);
        serve(1, 1, drops, tmo);
        chk("t4_restart_byte", 32'(cap_data[0]), 32'h01);
        cycles(2);
        rd_log.delete();
        bus.cd = 1'b1;
        @(negedge clk);
        bus.cd = 1'b0;
        chk("t4_drop_pulse", 32'({bus.frame_cd, bus.frame_err, bus.has_data}), 32'b010);
        cycles(8);
        chk("t4_hold", 32'(rd_log.size()), 32'd0);
        revalid();
        cycles(3);
        chk("t4_relaunch_addr", first_addr(), 32'd0);

        // Abort during CRC_L with a break pending
        serve(6, 3, drops, tmo);
        chk("t5_byte5", 32'(cap_data[5]), 32'hCC);
        bus.break_req = 1'b1;
        @(negedge clk);
        bus.break_req = 1'b0;
        chk("t5_break_set", 32'(bus.has_break), 32'd1);
        chk("t5_crc_l", 32'({bus.is_crc_byte, bus.is_last_byte, bus.data}),
            32'({1'b1, 1'b0, 8'h34}));
        d0 = n_done; e0 = n_err; c0 = n_cd;
        rd_log.delete();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5_abort_clr", 32'({bus.has_data, bus.has_break, bus.is_crc_byte}), 32'd0);
        cycles(3);
        chk("t5_no_pulses", 32'((n_done - d0) + (n_err - e0) + (n_cd - c0)), 32'd0);
        chk("t5_relaunch_addr", first_addr(), 32'd0);

        // Break request coincident with ack_break: clear wins
        bus.break_req = 1'b1;
        bus.ack_break = 1'b1;
        @(negedge clk);
        bus.break_req = 1'b0;
        bus.ack_break = 1'b0;
        chk("brk_clear_wins", 32'(bus.has_break), 32'd0);
        bus.break_req = 1'b1;
        @(negedge clk);
        bus.break_req = 1'b0;
        chk("brk_set", 32'(bus.has_break), 32'd1);

        // Asynchronous reset in the middle of SEND
        serve(2, 2, drops, tmo);
        cycles(3);
        chk("t6_mid_send", 32'({bus.has_data, bus.ram_rd_addr}), 32'({1'b1, 8'd2}));
        #1 reset = 1'b1;
        #1;
        chk("t6_async_rst", 32'({bus.has_data, bus.has_break, bus.is_crc_byte,
                                 bus.is_last_byte, bus.ram_rd_en}), 32'd0);
        chk("t6_async_vals", 32'({bus.data, bus.ram_rd_addr}), 32'd0);
        cycles(2);
        reset = 1'b0;
        rd_log.delete();
        cycles(3);
        chk("t6_post_rst_addr", first_addr(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "time limit");
    end

endmodule
